cache_ctrl: RTL and testbench

Sequencing controller for the 4-way set-associative, write-back, write-allocate cache. It owns the tag/valid/dirty/data arrays, serves one CPU request at a time, and runs victim write-back and refill over a req/ack memory port. It drives the external LRU block: it consumes that block's replacement way and pulses an update for every served access.

---
 rtl/cache_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - 4-way write-back/write-allocate cache sequencer; define CACHE_STATS_EN for hit/miss counters
module cache_ctrl #(
    parameter int WAYS       = 4,
    parameter int TOTAL_SIZE = 16,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    localparam int SETS      = TOTAL_SIZE / WAYS,
    localparam int IDX_W     = $clog2(SETS),
    localparam int WAY_W     = $clog2(WAYS),
    localparam int TAG_W     = ADDR_W - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lru_we,
    output logic [WAY_W-1:0]  lru_way,
    output logic [IDX_W-1:0]  lru_index,
    input  logic [WAY_W-1:0]  lru_replace_way,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

    state_t            state;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [WAY_W-1:0]  way_q;

    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [DATA_W-1:0] data_mem [SETS][WAYS];
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAYS-1:0]   dirty_q  [SETS];

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              lk_hit;
    logic [WAY_W-1:0]  lk_hit_way;
    logic              inv_found;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  lk_victim;
    logic              refill_done;
    logic              data_we;
    logic [WAY_W-1:0]  data_way;
    logic [DATA_W-1:0] data_wval;

    assign req_idx     = req_addr[IDX_W-1:0];
    assign req_tag     = req_addr[ADDR_W-1:IDX_W];
    assign refill_done = (state == REFILL) && mem_req && mem_ack;

    // Tag compare across the set; victim prefers the lowest invalid way over the LRU choice
    always_comb begin
        lk_hit     = 1'b0;
        lk_hit_way = '0;
        inv_found  = 1'b0;
        inv_way    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag) && !lk_hit) begin
                lk_hit     = 1'b1;
                lk_hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        lk_victim = inv_found ? inv_way : lru_replace_way;
    end

    // Line data written on a write hit, or on refill completion (write data wins over memory data)
    always_comb begin
        data_we   = ((state == LOOKUP) && lk_hit && req_we) || refill_done;
        data_way  = (state == LOOKUP) ? lk_hit_way : way_q;
        data_wval = (state == REFILL && !req_we) ? mem_rdata : req_wdata;
    end

    // Tag and data arrays carry no reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[req_idx][data_way] <= data_wval;
        end
        if (refill_done) begin
            tag_mem[req_idx][way_q] <= req_tag;
        end
    end

    // Main sequencer with registered CPU, memory and LRU outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            way_q     <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            cpu_hit   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lru_we    <= 1'b0;
            lru_way   <= '0;
            lru_index <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            cpu_ready <= 1'b0;
            lru_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        lru_index <= cpu_addr[IDX_W-1:0];
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lk_hit) begin
                        way_q     <= lk_hit_way;
                        cpu_hit   <= 1'b1;
                        cpu_rdata <= req_we ? req_wdata : data_mem[req_idx][lk_hit_way];
                        if (req_we) begin
                            dirty_q[req_idx][lk_hit_way] <= 1'b1;
                        end
                        cpu_ready <= 1'b1;
                        lru_we    <= 1'b1;
                        lru_way   <= lk_hit_way;
                        state     <= RESPOND;
                    end else begin
                        way_q   <= lk_victim;
                        cpu_hit <= 1'b0;
                        mem_req <= 1'b1;
                        if (valid_q[req_idx][lk_victim] && dirty_q[req_idx][lk_victim]) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_mem[req_idx][lk_victim], req_idx};
                            mem_wdata <= data_mem[req_idx][lk_victim];
                            state     <= WRITEBACK;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= req_addr;
                            mem_wdata <= '0;
                            state     <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_req && mem_ack) begin
                        mem_we    <= 1'b0;
                        mem_addr  <= req_addr;
                        mem_wdata <= '0;
                        state     <= REFILL;
                    end
                end
                REFILL: begin
                    if (refill_done) begin
                        mem_req                 <= 1'b0;
                        valid_q[req_idx][way_q] <= 1'b1;
                        dirty_q[req_idx][way_q] <= req_we;
                        cpu_rdata               <= data_wval;
                        cpu_ready               <= 1'b1;
                        lru_we                  <= 1'b1;
                        lru_way                 <= way_q;
                        state                   <= RESPOND;
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating hit/miss statistics, counted once per response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == RESPOND) begin
            if (cpu_hit) begin
                if (hit_count != 16'hFFFF) begin
                    hit_count <= hit_count + 16'd1;
                end
            end else begin
                if (miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - scoreboard bench for cache_ctrl with the LRU block and memory modelled in the loop
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic        cpu_hit;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        lru_we;
    logic [1:0]  lru_way;
    logic [1:0]  lru_index;
    logic [1:0]  lru_replace_way = '0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .lru_we(lru_we), .lru_way(lru_way), .lru_index(lru_index),
        .lru_replace_way(lru_replace_way),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } mem_t;

    typedef struct {
        logic [7:0] rdata;
        logic       hit;
        logic [1:0] way;
        logic [1:0] idx;
    } resp_t;

    mem_t  mem_q[$];
    resp_t resp_q[$];

    logic       m_valid [4][4];
    logic       m_dirty [4][4];
    logic [5:0] m_tag   [4][4];
    logic [7:0] m_data  [4][4];
    int         rank    [4][4];

    int passed = 0;
    int total = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                rank[s][w] = w;
            end
        end
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic touch(input int idx, input int way);
        for (int w = 0; w < 4; w++) begin
            if (rank[idx][w] < rank[idx][way]) rank[idx][w] = rank[idx][w] + 1;
        end
        rank[idx][way] = 0;
    endtask

    task automatic check_stats();
`ifdef CACHE_STATS_EN
        check("hit_count", 32'(hit_count), 32'(exp_hits));
        check("miss_count", 32'(miss_count), 32'(exp_misses));
`else
        check("hit_count_tied", 32'(hit_count), 32'd0);
        check("miss_count_tied", 32'(miss_count), 32'd0);
`endif
    endtask

    task automatic access(input logic we, input logic [7:0] addr, input logic [7:0] wd);
        int    idx;
        int    hw;
        int    v;
        int    waitc;
        bit    first_mem;
        bit    done;
        mem_t  me;
        mem_t  cur;
        resp_t re;
        idx = int'(addr[1:0]);
        v = 0;
        for (int w = 0; w < 4; w++) if (rank[idx][w] == 3) v = w;
        lru_replace_way = 2'(v);
        hw = -1;
        for (int w = 0; w < 4; w++) if (m_valid[idx][w] && m_tag[idx][w] == addr[7:2]) hw = w;
        if (hw >= 0) begin
            if (we) begin
                m_data[idx][hw] = wd;
                m_dirty[idx][hw] = 1'b1;
            end
            re = '{m_data[idx][hw], 1'b1, 2'(hw), addr[1:0]};
            exp_hits++;
        end else begin
            for (int w = 3; w >= 0; w--) if (!m_valid[idx][w]) v = w;
            if (m_valid[idx][v] && m_dirty[idx][v]) begin
                me = '{1'b1, {m_tag[idx][v], addr[1:0]}, m_data[idx][v]};
                mem_q.push_back(me);
            end
            me = '{1'b0, addr, 8'h00};
            mem_q.push_back(me);
            m_valid[idx][v] = 1'b1;
            m_tag[idx][v] = addr[7:2];
            m_data[idx][v] = we ? wd : (addr ^ 8'hA0);
            m_dirty[idx][v] = we;
            re = '{m_data[idx][v], 1'b0, 2'(v), addr[1:0]};
            exp_misses++;
            hw = v;
        end
        resp_q.push_back(re);
        touch(idx, hw);

        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wd;
        done = 0;
        waitc = 0;
        first_mem = 1;
        cur = '{1'b0, 8'h00, 8'h00};
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cpu_req = 1'b0;
                cpu_addr = ~addr;
                cpu_wdata = ~wd;
            end
            mem_ack = 1'b0;
            if (mem_req) begin
                if (waitc == 0) begin
                    if (first_mem) check("mem_req_rise_cycle", 32'(k), 32'd2);
                    first_mem = 0;
                    if (mem_q.size() == 0) begin
                        check("unexpected_mem_req", 32'(mem_req), 32'd0);
                    end else begin
                        cur = mem_q.pop_front();
                        check("mem_we", 32'(mem_we), 32'(cur.we));
                        check("mem_addr", 32'(mem_addr), 32'(cur.addr));
                        if (cur.we) check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
                    end
                end
                waitc++;
                if (waitc == 2) begin
                    check("mem_addr_stable", 32'(mem_addr), 32'(cur.addr));
                    mem_rdata = cur.addr ^ 8'hA0;
                    mem_ack = 1'b1;
                    waitc = 0;
                end
            end
            if (cpu_ready) begin
                re = resp_q.pop_front();
                check("lru_we_with_ready", 32'(lru_we), 32'd1);
                check("cpu_rdata", 32'(cpu_rdata), 32'(re.rdata));
                check("cpu_hit", 32'(cpu_hit), 32'(re.hit));
                check("lru_way", 32'(lru_way), 32'(re.way));
                check("lru_index", 32'(lru_index), 32'(re.idx));
                if (re.hit) check("hit_latency", 32'(k), 32'd2);
                check("mem_q_drained", 32'(mem_q.size()), 32'd0);
                done = 1;
            end else begin
                check("lru_we_idle", 32'(lru_we), 32'd0);
                check("lru_index_held", 32'(lru_index), 32'(addr[1:0]));
            end
        end
        if (!done) begin
            check("response_timeout", 32'(done), 32'd1);
            mem_q.delete();
            resp_q.delete();
            mem_ack = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_lru_we", 32'(lru_we), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_stats();

        // Cold read miss, then hit, then write hit that dirties the line
        access(1'b0, 8'h05, 8'h00);
        check("first_refill_way", 32'(m_data[1][0]), 32'hA5);
        access(1'b0, 8'h05, 8'h00);
        access(1'b1, 8'h05, 8'h11);

        // Fill set 1; 0x15 evicts dirty 0x05 via write-back
        access(1'b0, 8'h09, 8'h00);
        access(1'b0, 8'h0D, 8'h00);
        access(1'b0, 8'h11, 8'h00);
        access(1'b0, 8'h15, 8'h00);

        // Clean victim: refill only
        access(1'b0, 8'h19, 8'h00);
        access(1'b0, 8'h15, 8'h00);

        // Write miss allocates, later eviction writes back the written data
        access(1'b1, 8'h22, 8'h3C);
        access(1'b0, 8'h26, 8'h00);
        access(1'b0, 8'h2A, 8'h00);
        access(1'b0, 8'h2E, 8'h00);
        access(1'b0, 8'h32, 8'h00);

        @(negedge clk);
        check_stats();

        // Reset while a refill ack is being presented
        lru_replace_way = 2'd3;
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 8'h43;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("pre_rst_mem_req", 32'(mem_req), 32'd1);
        check("pre_rst_mem_addr", 32'(mem_addr), 32'h43);
        mem_rdata = 8'hE3;
        mem_ack = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_rst_mem_req", 32'(mem_req), 32'd0);
        check("async_rst_cpu_ready", 32'(cpu_ready), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_stats();
        access(1'b0, 8'h43, 8'h00);
        access(1'b0, 8'h05, 8'h00);
        access(1'b0, 8'h43, 8'h00);
        @(negedge clk);
        check_stats();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
